// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode and
// funct encodings, ALU operation codes and datapath mux encodings.
// Optional feature macro: MC_CONTROLLER_ADDI_EN (adds ADDIEX/ADDIWB states).
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
`ifdef MC_CONTROLLER_ADDI_EN
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`endif
        JEX     = 4'd11,
        ERROR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a request on the unified memory and may stall.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath plus memory (slave).
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu_ctrl_sig;
    logic       fault;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, pc_en,
               alu_ctrl_sig, fault
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, pc_en,
               alu_ctrl_sig, fault
    );
endinterface

// File: rtl/mc_controller_alu_dec.sv
// R-type funct field to ALU operation decode; o_valid flags a known funct.
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_valid
);

    // Map the funct field onto an ALU code; unknown functs yield AND/invalid.
    always_comb begin
        o_alu_ctrl = ALU_AND;
        o_valid    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style controller with stall watchdog on memory accesses.
// Optional feature macro: MC_CONTROLLER_ADDI_EN enables addi execution;
// without it addi is treated as an illegal opcode.
module mc_controller
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic           i_clk,
    input  logic           i_reset,
    mc_controller_if.master io_bus
);

    // Last counter value at which a further stalled cycle means a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       w_stall;
    logic       w_timeout;
    logic       w_pc_write;
    logic       w_branch;
    logic [2:0] w_fn_ctrl;
    logic       w_fn_valid;

    alu_dec u_alu_dec (
        .i_funct    (io_bus.funct),
        .o_alu_ctrl (w_fn_ctrl),
        .o_valid    (w_fn_valid)
    );

    assign w_stall   = is_mem_state(r_state) && !io_bus.mem_ready;
    assign w_timeout = w_stall && (r_wait >= WAIT_LAST);
    assign io_bus.pc_en = w_pc_write | (w_branch & io_bus.zero);

    // State register; reset aborts whatever access is in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Stall counter: cleared on every state change, counts stalled cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait <= 8'd0;
        end else if (w_stall) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= r_wait;
        end
    end

    // Next-state and per-state control outputs; unnamed outputs stay 0.
    always_comb begin
        w_next              = r_state;
        w_pc_write          = 1'b0;
        w_branch            = 1'b0;
        io_bus.mem_req      = 1'b0;
        io_bus.iord         = 1'b0;
        io_bus.mem_write    = 1'b0;
        io_bus.ir_write     = 1'b0;
        io_bus.reg_write    = 1'b0;
        io_bus.reg_dst      = 1'b0;
        io_bus.mem_to_reg   = 1'b0;
        io_bus.alu_src_a    = 1'b0;
        io_bus.alu_src_b    = SRCB_RT;
        io_bus.pc_src       = PCSRC_ALU;
        io_bus.alu_ctrl_sig = 3'b000;
        io_bus.fault        = 1'b0;
        case (r_state)
            FETCH: begin
                io_bus.mem_req      = 1'b1;
                io_bus.alu_src_b    = SRCB_FOUR;
                io_bus.alu_ctrl_sig = ALU_ADD;
                if (io_bus.mem_ready) begin
                    io_bus.ir_write = 1'b1;
                    w_pc_write      = 1'b1;
                    w_next          = DECODE;
                end else if (w_timeout) begin
                    w_next = ERROR;
                end else begin
                    w_next = FETCH;
                end
            end
            DECODE: begin
                io_bus.alu_src_b = SRCB_IMM;
                case (io_bus.op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
`ifdef MC_CONTROLLER_ADDI_EN
                    OP_ADDI:      w_next = ADDIEX;
`else
                    OP_ADDI:      w_next = ERROR;
`endif
                    OP_J:         w_next = JEX;
                    default:      w_next = ERROR;
                endcase
            end
            MEMADR: begin
                io_bus.alu_src_a    = 1'b1;
                io_bus.alu_src_b    = SRCB_IMM;
                io_bus.alu_ctrl_sig = ALU_ADD;
                if (io_bus.op == OP_LW) begin
                    w_next = MEMRD;
                end else if (io_bus.op == OP_SW) begin
                    w_next = MEMWR;
                end else begin
                    w_next = ERROR;
                end
            end
            MEMRD, MEMWR: begin
                io_bus.mem_req   = 1'b1;
                io_bus.iord      = 1'b1;
                io_bus.mem_write = (r_state == MEMWR);
                if (io_bus.mem_ready) begin
                    w_next = (r_state == MEMRD) ? MEMWB : FETCH;
                end else if (w_timeout) begin
                    w_next = ERROR;
                end else begin
                    w_next = r_state;
                end
            end
            MEMWB: begin
                io_bus.reg_write  = 1'b1;
                io_bus.mem_to_reg = 1'b1;
                w_next            = FETCH;
            end
            RTYPEEX: begin
                io_bus.alu_src_a    = 1'b1;
                io_bus.alu_src_b    = SRCB_RT;
                io_bus.alu_ctrl_sig = w_fn_ctrl;
                w_next              = w_fn_valid ? RTYPEWB : ERROR;
            end
            RTYPEWB: begin
                io_bus.reg_write = 1'b1;
                io_bus.reg_dst   = 1'b1;
                w_next           = FETCH;
            end
            BEQEX: begin
                io_bus.alu_src_a    = 1'b1;
                io_bus.alu_src_b    = SRCB_RT;
                io_bus.alu_ctrl_sig = ALU_SUB;
                io_bus.pc_src       = PCSRC_ALUOUT;
                w_branch            = 1'b1;
                w_next              = FETCH;
            end
`ifdef MC_CONTROLLER_ADDI_EN
            ADDIEX: begin
                io_bus.alu_src_a    = 1'b1;
                io_bus.alu_src_b    = SRCB_IMM;
                io_bus.alu_ctrl_sig = ALU_ADD;
                w_next              = ADDIWB;
            end
            ADDIWB: begin
                io_bus.reg_write = 1'b1;
                w_next           = FETCH;
            end
`endif
            JEX: begin
                w_pc_write    = 1'b1;
                io_bus.pc_src = PCSRC_JUMP;
                w_next        = FETCH;
            end
            ERROR: begin
                io_bus.fault = 1'b1;
                w_next       = ERROR;
            end
            default: begin
                w_next = ERROR;
            end
        endcase
    end

endmodule
